// File: rtl/joypad_port_if.sv
`default_nettype none
// ============================================================================
// Module      : joypad_port_if
// Description : CPU-side bus bundle for the $4016/$4017 controller ports:
//               read strobes, OUT latch bits, read data and its enable.
// Revision    : 1.0  initial release
// ============================================================================
interface joypad_port_if;
    logic       naddr4016r;   // active-low read of $4016 (pad 1)
    logic       naddr4017r;   // active-low read of $4017 (pad 2)
    logic [2:0] addr4016w;    // OUT2..OUT0 as latched by $4016 writes
    logic [7:0] joy_data;     // read data toward the CPU data_in mux
    logic       joy_oe;       // read data valid this cycle

    // CPU / bus-decoder side
    modport master (
        output naddr4016r,
        output naddr4017r,
        output addr4016w,
        input  joy_data,
        input  joy_oe
    );

    // Controller-port responder side
    modport slave (
        input  naddr4016r,
        input  naddr4017r,
        input  addr4016w,
        output joy_data,
        output joy_oe
    );
endinterface
`default_nettype wire

// File: rtl/joypad_port.sv
`default_nettype none
// ============================================================================
// Module      : joypad_port
// Description : Two standard NES pads behind the $4016/$4017 read strobes.
//               Each pad is an 8-bit parallel-load / serial-out register
//               loaded while OUT0 is high and advanced once per read burst.
//               Optional turbo (macro JOYPAD_TURBO_EN) ORs a square wave
//               into the A/B buttons of either pad.
// Revision    : 1.0  initial release
// ============================================================================
module joypad_port #(
    parameter logic [6:0] OPEN_BUS_HI       = 7'h20,
    parameter int         TURBO_HALF_PERIOD = 14915
) (
    input  logic          clock,
    input  logic          reset,
    joypad_port_if.slave  bus,
    input  logic [7:0]    buttons_p1,
    input  logic [7:0]    buttons_p2,
    input  logic [1:0]    turbo_p1,
    input  logic [1:0]    turbo_p2
);

    logic       w_strobe;
    logic       w_rd1;
    logic       w_rd2;
    logic [7:0] w_eff_p1;
    logic [7:0] w_eff_p2;
    logic       w_bit1;
    logic       w_bit2;

    logic [7:0] r_sr1;
    logic [7:0] r_sr2;
    logic       r_rd1_prev;
    logic       r_rd2_prev;

    // Only OUT0 matters to a standard pad; OUT1/OUT2 are expansion-port lines.
    logic w_unused_out;
    assign w_unused_out = ^bus.addr4016w[2:1];

    assign w_strobe = bus.addr4016w[0];
    assign w_rd1    = ~bus.naddr4016r;
    assign w_rd2    = ~bus.naddr4017r;

`ifdef JOYPAD_TURBO_EN
    localparam logic [15:0] c_turbo_last = 16'(TURBO_HALF_PERIOD - 1);

    logic [15:0] r_turbo_cnt;
    logic        r_turbo_phase;

    // Free-running half-period counter; phase flips each time it wraps.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_turbo_cnt   <= 16'd0;
            r_turbo_phase <= 1'b0;
        end else if (r_turbo_cnt == c_turbo_last) begin
            r_turbo_cnt   <= 16'd0;
            r_turbo_phase <= ~r_turbo_phase;
        end else begin
            r_turbo_cnt   <= r_turbo_cnt + 16'd1;
        end
    end

    assign w_eff_p1 = buttons_p1 | {6'b0, turbo_p1 & {2{r_turbo_phase}}};
    assign w_eff_p2 = buttons_p2 | {6'b0, turbo_p2 & {2{r_turbo_phase}}};
`else
    // Turbo hardware is absent: the turbo selects and period have no effect.
    localparam int c_unused_half_period = TURBO_HALF_PERIOD;
    logic w_unused_turbo;
    assign w_unused_turbo = ^{turbo_p1, turbo_p2};

    assign w_eff_p1 = buttons_p1;
    assign w_eff_p2 = buttons_p2;
`endif

    // While strobed the pad is transparent, so the serial bit is the live A.
    assign w_bit1 = w_strobe ? w_eff_p1[0] : r_sr1[0];
    assign w_bit2 = w_strobe ? w_eff_p2[0] : r_sr2[0];

    // Parallel load while strobed, else one shift at the start of each read burst.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sr1 <= 8'h00;
            r_sr2 <= 8'h00;
        end else if (w_strobe) begin
            r_sr1 <= w_eff_p1;
            r_sr2 <= w_eff_p2;
        end else begin
            if (w_rd1 && r_rd1_prev) begin
                r_sr1 <= {1'b1, r_sr1[7:1]};
            end
            if (w_rd2 && r_rd2_prev) begin
                r_sr2 <= {1'b1, r_sr2[7:1]};
            end
        end
    end

    // Remember the previous strobe level so a multi-cycle read shifts only once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rd1_prev <= 1'b1;
            r_rd2_prev <= 1'b1;
        end else begin
            r_rd1_prev <= bus.naddr4016r;
            r_rd2_prev <= bus.naddr4017r;
        end
    end

    // Read-data mux: $4016 has priority if both strobes are (illegally) low.
    always_comb begin
        bus.joy_oe   = w_rd1 | w_rd2;
        bus.joy_data = 8'h00;
        if (w_rd1) begin
            bus.joy_data = {OPEN_BUS_HI, w_bit1};
        end else if (w_rd2) begin
            bus.joy_data = {OPEN_BUS_HI, w_bit2};
        end
    end

endmodule
`default_nettype wire
